// File: rtl/thermo_frame_pkg.sv
// Shared definitions for the thermocouple sample framer: frame geometry,
// field offsets, serializer state encoding and the frame packing helper.
package thermo_frame_pkg;

  localparam int FRAME_W = 24;

  // Field bit offsets inside the 24-bit frame (MSB is sent first).
  localparam int SYNC_HI = 23;
  localparam int SYNC_LO = 16;
  localparam int TEMP_HI = 15;
  localparam int TEMP_LO = 8;
  localparam int SEQ_HI  = 7;
  localparam int SEQ_LO  = 4;
  localparam int OVR_BIT = 3;
  localparam int SAT_BIT = 2;

  // Serializer state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  // Assemble {SYNC, TEMP, SEQ, OVR, SAT, 2'b00}.
  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [7:0] sync,
    input logic [7:0] temp,
    input logic [3:0] seq,
    input logic       ovr,
    input logic       sat
  );
    logic [FRAME_W-1:0] f;
    f                  = '0;
    f[SYNC_HI:SYNC_LO] = sync;
    f[TEMP_HI:TEMP_LO] = temp;
    f[SEQ_HI:SEQ_LO]   = seq;
    f[OVR_BIT]         = ovr;
    f[SAT_BIT]         = sat;
    return f;
  endfunction

endpackage

// File: rtl/thermo_sample_framer_serializer.sv
// Frame serializer: waits for a pending result, loads the 24-bit frame,
// shifts it out MSB first with a divided bit clock, then idles for a gap.
module frame_serializer
  import thermo_frame_pkg::*;
#(
  parameter int         BIT_DIV    = 4,
  parameter int         GAP_CYCLES = 8,
  parameter logic [7:0] SYNC_WORD  = DEFAULT_SYNC_WORD
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] temp,
  input  logic       sat,
  input  logic       ovr,
  output logic       load,
  output logic       ser_clk,
  output logic       ser_data,
  output logic       dfrm
);

  localparam int PH_W  = $clog2(BIT_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(BIT_DIV / 2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [4:0]       BIT_LAST = 5'(FRAME_W - 1);

  logic [1:0]         state;
  logic [FRAME_W-1:0] shreg;
  logic [4:0]         bit_cnt;
  logic [PH_W-1:0]    phase;
  logic [GAP_W-1:0]   gap_cnt;
  logic [3:0]         seq;

  // FSM, shift register, bit/phase/gap counters and frame sequence number.
  // NOTE: sequential state uses <= so every register sees pre-edge values;
  // blocking = here would make the result depend on statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      gap_cnt <= '0;
      seq     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) state <= ST_LOAD;
        ST_LOAD: begin
          shreg   <= pack_frame(SYNC_WORD, temp, seq, ovr, sat);
          seq     <= seq + 4'd1;
          phase   <= '0;
          bit_cnt <= '0;
          state   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            shreg <= {shreg[FRAME_W-2:0], 1'b0};
            if (bit_cnt == BIT_LAST) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        ST_GAP: begin
          // Skipping the idle cycle when work is already waiting gives the
          // tightest back-to-back frame spacing of LOAD + SHIFT + GAP.
          if (gap_cnt == GAP_LAST) state <= start ? ST_LOAD : ST_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Line outputs are pure decodes of registered state, so they are held low
  // outside SHIFT and drop the edge after a reset aborts a frame.
  assign load     = (state == ST_LOAD);
  assign dfrm     = (state == ST_SHIFT);
  assign ser_data = dfrm & shreg[FRAME_W-1];
  assign ser_clk  = dfrm & (phase >= PH_HALF);

endmodule

// File: rtl/thermo_sample_framer.sv
// Thermocouple sample framer: averages 2^AVG_LOG2 ADC samples, scales the
// average to a saturating 8-bit code, holds it in a one-entry pending
// register and hands it to the serializer as a framed 24-bit word.
module thermo_sample_framer
  import thermo_frame_pkg::*;
#(
  parameter int         AVG_LOG2   = 2,
  parameter int         TEMP_LSB   = 12,
  parameter int         BIT_DIV    = 4,
  parameter int         GAP_CYCLES = 8,
  parameter logic [7:0] SYNC_WORD  = DEFAULT_SYNC_WORD
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [23:0] SAMPLE_I,
  input  logic        SAMPLE_VALID_I,
  input  logic        CLR_OVR_I,
  output logic [7:0]  TEMP_O,
  output logic        TEMP_VALID_O,
  output logic        OVERRUN_O,
  output logic        SER_CLK_O,
  output logic        SER_DATA_O,
  output logic        DFRM_O
);

  localparam int ACC_W = 24 + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [23:0]      avg;
  logic             avg_stb;
  logic [7:0]       temp_c;
  logic             sat_c;
  logic [7:0]       pend_temp;
  logic             pend_sat;
  logic             pend_full;
  logic             load;

  assign sum = acc + ACC_W'(SAMPLE_I);

  // Averager: accumulate samples, emit the truncated mean on the last one.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      acc     <= '0;
      cnt     <= '0;
      avg     <= '0;
      avg_stb <= 1'b0;
    end else begin
      avg_stb <= 1'b0;
      if (SAMPLE_VALID_I) begin
        if (cnt == CNT_LAST) begin
          avg     <= 24'(sum >> AVG_LOG2);
          avg_stb <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Scaler: pick the 8-bit window, saturate if anything above it is set.
  // NOTE: both outputs are assigned on every path, so no latch is inferred.
  always_comb begin
    sat_c  = |(avg >> (TEMP_LSB + 8));
    temp_c = sat_c ? 8'hFF : 8'(avg >> TEMP_LSB);
  end

  // Result register, pending entry and sticky overrun flag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      TEMP_O       <= '0;
      TEMP_VALID_O <= 1'b0;
      pend_temp    <= '0;
      pend_sat     <= 1'b0;
      pend_full    <= 1'b0;
      OVERRUN_O    <= 1'b0;
    end else begin
      TEMP_VALID_O <= avg_stb;
      if (avg_stb) begin
        TEMP_O    <= temp_c;
        pend_temp <= temp_c;
        pend_sat  <= pend_sat & 1'b0 | sat_c;
      end
      // A new result beats the LOAD clear so it is never dropped.
      if (avg_stb)   pend_full <= 1'b1;
      else if (load) pend_full <= 1'b0;
      // During LOAD the old entry is being copied out, so replacing it loses
      // nothing; only a true overwrite of an unsent entry flags overrun, and
      // it wins over a simultaneous clear.
      if (avg_stb && pend_full && !load) OVERRUN_O <= 1'b1;
      else if (CLR_OVR_I)                OVERRUN_O <= 1'b0;
    end
  end

  frame_serializer #(
    .BIT_DIV    (BIT_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .SYNC_WORD  (SYNC_WORD)
  ) u_serializer (
    .clk      (CLK),
    .rst_n    (RESET),
    .start    (pend_full),
    .temp     (pend_temp),
    .sat      (pend_sat),
    .ovr      (OVERRUN_O),
    .load     (load),
    .ser_clk  (SER_CLK_O),
    .ser_data (SER_DATA_O),
    .dfrm     (DFRM_O)
  );

endmodule

// File: tb/tb_thermo_sample_framer.sv
// Self-checking bench for thermo_sample_framer: directed scenarios plus
// randomized averaging runs compared against an arithmetic reference model.
module tb_thermo_sample_framer;

  localparam int BIT_DIV    = 4;
  localparam int GAP_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] sample = '0;
  logic        valid = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  temp;
  logic        temp_valid;
  logic        overrun;
  logic        ser_clk;
  logic        ser_data;
  logic        dfrm;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [23:0] word;
    int          nbits;
    int          hi;
  } cap_t;
  cap_t cap_q[$];

  always #5 clk = ~clk;

  thermo_sample_framer #(
    .AVG_LOG2   (2),
    .TEMP_LSB   (12),
    .BIT_DIV    (BIT_DIV),
    .GAP_CYCLES (GAP_CYCLES),
    .SYNC_WORD  (8'hA5)
  ) dut (
    .CLK            (clk),
    .RESET          (rst_n),
    .SAMPLE_I       (sample),
    .SAMPLE_VALID_I (valid),
    .CLR_OVR_I      (clr),
    .TEMP_O         (temp),
    .TEMP_VALID_O   (temp_valid),
    .OVERRUN_O      (overrun),
    .SER_CLK_O      (ser_clk),
    .SER_DATA_O     (ser_data),
    .DFRM_O         (dfrm)
  );

  // Line receiver: sample data on SER_CLK_O rising, record each frame when
  // DFRM_O falls together with its bit count and envelope length.
  initial begin : monitor
    logic [23:0] sh;
    int          nb;
    int          hi;
    logic        p_sclk;
    logic        p_dfrm;
    sh = '0; nb = 0; hi = 0; p_sclk = 1'b0; p_dfrm = 1'b0;
    forever begin
      @(negedge clk);
      if (dfrm) begin
        hi = hi + 1;
        if (ser_clk && !p_sclk) begin
          sh = {sh[22:0], ser_data};
          nb = nb + 1;
        end
      end else if (p_dfrm) begin
        cap_q.push_back('{word: sh, nbits: nb, hi: hi});
        sh = '0; nb = 0; hi = 0;
      end
      p_dfrm = dfrm;
      p_sclk = ser_clk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: truncated mean of four samples, byte at bit 12,
  // saturate when the mean reaches 2^20.
  function automatic logic [8:0] model_result(input longint unsigned total);
    longint unsigned mean;
    mean = total / 4;
    if (mean >= (64'd1 << 20)) return {1'b1, 8'hFF};
    return {1'b0, 8'((mean / 4096) % 256)};
  endfunction

  function automatic logic [23:0] model_frame(input logic [8:0] res, input int seq, input logic ovr);
    return {8'hA5, res[7:0], 4'(seq % 16), ovr, res[8], 2'b00};
  endfunction

  task automatic drive(input logic [23:0] s);
    @(negedge clk);
    valid  = 1'b1;
    sample = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  // Four strobes (optionally with random gaps), then check the result pulse.
  task automatic run_avg(input string tag, input logic [23:0] s0, s1, s2, s3,
                         input bit gaps, output logic [8:0] res);
    logic [23:0]     s[4];
    longint unsigned total;
    s = '{s0, s1, s2, s3};
    total = 0;
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      total += s[i];
      if (gaps && i < 3) idle($urandom_range(0, 3));
    end
    idle(1);
    res = model_result(total);
    @(negedge clk);
    check({tag, "_tvalid"}, 32'(temp_valid), 1);
    check({tag, "_temp"}, 32'(temp), 32'(res[7:0]));
    @(negedge clk);
    check({tag, "_tvalid_end"}, 32'(temp_valid), 0);
  endtask

  task automatic expect_frame(input string tag, input logic [23:0] exp);
    bit   found;
    cap_t c;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (cap_q.size() > 0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_seen"}, 32'(found), 1);
    if (found) begin
      c = cap_q.pop_front();
      check(tag, 32'(c.word), 32'(exp));
      check({tag, "_bits"}, 32'(c.nbits), 24);
      check({tag, "_dfrm_len"}, 32'(c.hi), 32'(24 * BIT_DIV));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cap_q.delete();
  endtask

  initial begin : stimulus
    logic [8:0]  res;
    logic [23:0] r[4];
    bit          seen;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_temp", 32'(temp), 0);
    check("rst_tvalid", 32'(temp_valid), 0);
    check("rst_ovr", 32'(overrun), 0);
    check("rst_sclk", 32'(ser_clk), 0);
    check("rst_sdata", 32'(ser_data), 0);
    check("rst_dfrm", 32'(dfrm), 0);
    rst_n = 1'b1;

    // Nominal average, truncation and saturation.
    run_avg("avg19", 24'h019000, 24'h019000, 24'h019000, 24'h019000, 1'b0, res);
    check("avg19_temp_const", 32'(temp), 32'h19);
    expect_frame("avg19_frame", model_frame(res, 0, 1'b0));
    idle(GAP_CYCLES + 2);

    run_avg("trunc", 24'h000FFF, 24'h000FFF, 24'h001000, 24'h001000, 1'b0, res);
    expect_frame("trunc_frame", model_frame(res, 1, 1'b0));
    idle(GAP_CYCLES + 2);

    run_avg("sat", 24'h100000, 24'h100000, 24'h100000, 24'h100000, 1'b0, res);
    expect_frame("sat_frame", model_frame(res, 2, 1'b0));
    idle(GAP_CYCLES + 2);

    // Twelve back-to-back strobes: third result overwrites the second.
    do_reset();
    for (int i = 0; i < 12; i++) drive(24'h019000);
    idle(1);
    repeat (3) @(negedge clk);
    check("ovr_set", 32'(overrun), 1);
    expect_frame("ovr_frame0", 24'hA51900);
    expect_frame("ovr_frame1", 24'hA51918);
    check("ovr_sticky", 32'(overrun), 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);
    repeat (150) @(negedge clk);
    check("ovr_no_extra_frame", 32'(cap_q.size()), 0);

    // Reset at bit 10 of a frame.
    do_reset();
    run_avg("abort", 24'h019000, 24'h019000, 24'h019000, 24'h019000, 1'b0, res);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dfrm) seen = 1'b1;
    end
    check("abort_dfrm_rise", 32'(seen), 1);
    repeat (10 * BIT_DIV - 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_dfrm", 32'(dfrm), 0);
    check("abort_sclk", 32'(ser_clk), 0);
    check("abort_sdata", 32'(ser_data), 0);
    check("abort_temp", 32'(temp), 0);
    check("abort_tvalid", 32'(temp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cap_q.delete();
    for (int i = 0; i < 4; i++) r[i] = 24'($urandom) & 24'h0FFFFF;
    run_avg("fresh", r[0], r[1], r[2], r[3], 1'b1, res);
    expect_frame("fresh_frame", model_frame(res, 0, 1'b0));
    idle(GAP_CYCLES + 2);

    // Seventeen randomized runs: SEQ wraps 15 -> 0 on frame 16.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      for (int i = 0; i < 4; i++)
        r[i] = ($urandom_range(0, 2) == 0) ? 24'($urandom) : (24'($urandom) & 24'h0FFFFF);
      run_avg($sformatf("rnd%0d", k), r[0], r[1], r[2], r[3], 1'b1, res);
      expect_frame($sformatf("rnd%0d_frame", k), model_frame(res, k, 1'b0));
      idle(GAP_CYCLES + 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/thermo_sample_framer.md
# thermo_sample_framer

Downstream consumer of the thermocouple SPI ADC controller's 24-bit conversion results. It averages 2^AVG_LOG2 consecutive samples and scales the average to an 8-bit temperature code with saturation. It also serializes each result as a 24-bit framed word on a three-wire output: SER_CLK_O, SER_DATA_O and DFRM_O. It sits between the ADC SPI master and the board-level serial data link.

## Interface
- AVG_LOG2, 2: log2 of samples per average; legal range 0..4.
- TEMP_LSB, 12: bit index of the average that maps to temperature bit 0; legal range 0..16.
- BIT_DIV, 4: CLK cycles per serial bit; must be even and at least 2.
- GAP_CYCLES, 8: idle CLK cycles after each frame, with DFRM_O low; must be at least 1.
- SYNC_WORD, 8'hA5: frame header byte.

Ports (name, direction, width, meaning):
- CLK  in  1  single system clock; every register updates on its rising edge.
- RESET  in  1  reset is synchronous and active-low.
- SAMPLE_I  in  24  unsigned ADC conversion result.
- SAMPLE_VALID_I  in  1  one-cycle strobe; SAMPLE_I is valid in the same cycle.
- CLR_OVR_I  in  1  one-cycle pulse that clears OVERRUN_O.
- TEMP_O  out  8  latest temperature code.
- TEMP_VALID_O  out  1  one-cycle pulse when TEMP_O updates.
- OVERRUN_O  out  1  sticky flag: an unsent result was overwritten.
- SER_CLK_O  out  1  serial bit clock.
- SER_DATA_O  out  1  serial data, MSB first.
- DFRM_O  out  1  frame envelope; high for all 24 bits of a frame.

## Operation
- Accumulator is 24+AVG_LOG2 bits wide with a sample counter of AVG_LOG2 bits. Each SAMPLE_VALID_I adds SAMPLE_I to the accumulator.
- On the 2^AVG_LOG2-th sample:
  - avg = sum >> AVG_LOG2, truncated.
  - Accumulator and counter restart from the next sample.
  - Averaging never stalls, including while a frame is being sent.
- Scaling:
  - TEMP = avg[TEMP_LSB+7:TEMP_LSB].
  - If any bit of avg above TEMP_LSB+7 is set, TEMP = 8'hFF and SAT = 1. Otherwise SAT = 0.
- Each result is written into a one-entry pending register holding {TEMP, SAT} and sets pending_full.
- If pending_full is already set when a new result is written, the register is overwritten and OVERRUN_O is set.
- OVERRUN_O clears on CLR_OVR_I. If the clear and a new overrun occur in the same cycle, the overrun wins.
- Frame layout, 24 bits, MSB first: {SYNC_WORD[7:0], TEMP[7:0], SEQ[3:0], OVR, SAT, 2'b00}.
  - SEQ is a 4-bit frame counter that wraps 15 -> 0.
  - OVR is the value of OVERRUN_O at LOAD.
- Serializer FSM:
  - IDLE: go to LOAD when pending_full = 1.
  - LOAD (1 cycle): copy the frame into the shift register, clear pending_full, then SEQ++ (the first frame after reset carries SEQ = 0).
  - SHIFT (24*BIT_DIV cycles): send the 24 bits.
  - GAP (GAP_CYCLES cycles): idle.
  - Then return to IDLE.
- A result that lands during LOAD is not lost: the set takes priority over the LOAD clear.
- Outputs in IDLE, LOAD and GAP: SER_CLK_O = 0, SER_DATA_O = 0, DFRM_O = 0.

## Timing
- Reset values: TEMP_O 0, TEMP_VALID_O 0, OVERRUN_O 0, SER_CLK_O 0, SER_DATA_O 0, DFRM_O 0.
- Reset also clears the accumulator, sample counter, pending register, SEQ and FSM (to IDLE).
- Reset asserted mid-frame aborts the frame at the next edge. SAMPLE_VALID_I is ignored while RESET is low.
- Latency: the final sample's strobe at edge n updates TEMP_O at edge n+1. TEMP_VALID_O is high for exactly the cycle after edge n+1, and pending_full is set at that same edge.
- From pending_full set, LOAD takes 1 cycle. DFRM_O rises one cycle after LOAD.
- Each bit occupies BIT_DIV cycles:
  - SER_CLK_O is low for the first BIT_DIV/2 cycles and high for the second half.
  - SER_DATA_O changes only at bit start, so the receiver samples on the rising edge of SER_CLK_O.
- DFRM_O is high for exactly 24*BIT_DIV cycles.
- Minimum frame-to-frame spacing is 1 + 24*BIT_DIV + GAP_CYCLES cycles.

## Structure
- Shared package thermo_frame_pkg holds:
  - FRAME_W = 24 and the field bit offsets (SYNC 23:16, TEMP 15:8, SEQ 7:4, OVR 3, SAT 2);
  - the FSM state encoding (IDLE, LOAD, SHIFT, GAP);
  - the default SYNC_WORD.
- Sub-module frame_serializer (FSM, bit/phase counters, shift register) is instantiated once. The top level contains the averager, the scaler and the pending register.

## Test plan
All scenarios use default parameters unless stated.
- Four strobes of 24'h019000 -> TEMP_O = 8'h19 with a single TEMP_VALID_O pulse; frame = 24'hA51900; DFRM_O is high for 96 cycles.
- Samples 24'h000FFF, 24'h000FFF, 24'h001000, 24'h001000 -> avg 24'h000FFF (truncated) -> TEMP_O = 8'h00.
- Four strobes of 24'h100000 -> SAT = 1, TEMP_O = 8'hFF, frame = 24'hA5FF04.
- Twelve back-to-back strobes of 24'h019000:
  - frame 0 = 24'hA51900;
  - the third result overwrites the pending second one, so OVERRUN_O = 1;
  - frame 1 = 24'hA51918;
  - pulsing CLR_OVR_I afterwards -> OVERRUN_O = 0.
- Reset pulse at bit 10 of a frame -> all outputs are 0 at the next edge; a fresh 4-sample run produces a frame with SEQ = 0.
- Seventeen consecutive averaging runs -> SEQ wraps 15 -> 0 on frame 16.
